// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - buffers X/W operand matrices and streams them diagonally skewed into the systolic array
module systolic_skew_feeder #(
  parameter int N        = 9,
  parameter int DW       = 32,
  parameter int PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            load_sel,
  input  logic [3:0]      load_idx,
  input  logic [N*DW-1:0] load_vec,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            load_err,
  output logic [N*DW-1:0] data_arr,
  output logic [N*DW-1:0] wt_arr
);

  localparam int STREAM_LEN = 2*N - 1;
  localparam int FLUSH_LEN  = 2*N - 2 + PIPE_LAT;
  localparam int MAX_LEN    = (FLUSH_LEN > STREAM_LEN) ? FLUSH_LEN : STREAM_LEN;
  localparam int CW         = $clog2(MAX_LEN);
  localparam int IW         = $clog2(N);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   step, step_nxt;
  logic [N*DW-1:0] x_buf [N];
  logic [N*DW-1:0] w_buf [N];
  logic [N*DW-1:0] skew_d, skew_w;
  logic            start_acc, load_acc, load_oob;

  assign start_acc = (state == IDLE) && start;
  assign load_acc  = load_valid && load_ready;
  assign load_oob  = int'(load_idx) >= N;

  // Operand storage is deliberately not reset; contents persist across runs.
  always_ff @(posedge clk) begin
    if (load_acc && !load_oob) begin
      if (load_sel)
        w_buf[load_idx[IW-1:0]] <= load_vec;
      else
        x_buf[load_idx[IW-1:0]] <= load_vec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          step_nxt  = '0;
        end
      end
      STREAM: begin
        if (step == CW'(STREAM_LEN - 1)) begin
          state_nxt = FLUSH;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      FLUSH: begin
        if (step == CW'(FLUSH_LEN - 1)) begin
          state_nxt = DONE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state == STREAM) || (state == FLUSH);
    done       = (state == DONE);
    load_ready = (state == IDLE) && !start;
  end

  // Lane k at step t carries row t-k of the buffered matrix, else zero.
  always_comb begin
    skew_d = '0;
    skew_w = '0;
    for (int k = 0; k < N; k++) begin
      int r;
      logic [IW-1:0] ridx;
      r    = int'(step_nxt) - k;
      ridx = IW'(r);
      if (r >= 0 && r < N) begin
        skew_d[N*DW-1-k*DW -: DW] = x_buf[ridx][N*DW-1-k*DW -: DW];
        skew_w[N*DW-1-k*DW -: DW] = w_buf[ridx][N*DW-1-k*DW -: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_arr <= '0;
      wt_arr   <= '0;
    end else if (state_nxt == STREAM) begin
      data_arr <= skew_d;
      wt_arr   <= skew_w;
    end else begin
      data_arr <= '0;
      wt_arr   <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      load_err <= 1'b0;
    else if (start_acc)
      load_err <= 1'b0;
    else if (load_acc && load_oob)
      load_err <= 1'b1;
  end

endmodule
